// File: rtl/dbus_ram_responder.sv
// Single-port data RAM acting as a data-bus responder for the core's load/store unit.
// Accepts one request at a time, waits WAIT_STATES cycles, and then returns a one-cycle rvalid response.
module dbus_ram_responder #(
    parameter int unsigned DEPTH_WORDS = 1024,
    parameter int unsigned WAIT_STATES = 1,
    parameter logic [31:0] BASE_ADDR   = 32'h0001_0000
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        req,
    input  logic        we,
    input  logic [3:0]  be,
    input  logic [31:0] addr,
    input  logic [31:0] wdata,
    output logic        gnt,
    output logic        rvalid,
    output logic [31:0] rdata,
    output logic        err
);

    localparam int unsigned IDX_W     = (DEPTH_WORDS > 32'd1) ? $clog2(DEPTH_WORDS) : 1;
    localparam logic [31:0] WIN_BYTES = 32'(DEPTH_WORDS * 32'd4);
    localparam logic [3:0]  WAIT_LOAD = (WAIT_STATES > 32'd0) ? 4'(WAIT_STATES - 32'd1) : 4'd0;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_WAIT = 2'd1,
        ST_RESP = 2'd2
    } state_t;

    state_t             state_r;
    state_t             state_nxt_s;
    logic [3:0]         cnt_r;
    logic [3:0]         cnt_nxt_s;
    logic               accept_s;
    logic               commit_s;
    logic [31:0]        offset_s;
    logic               in_range_in_s;
    logic [IDX_W-1:0]   idx_in_s;

    logic               in_range_r;
    logic [IDX_W-1:0]   idx_r;
    logic               we_r;
    logic [3:0]         be_r;
    logic [31:0]        wdata_r;

    logic               cur_in_range_s;
    logic [IDX_W-1:0]   cur_idx_s;
    logic               cur_we_s;
    logic [3:0]         cur_be_s;
    logic [31:0]        cur_wdata_s;

    logic               rvalid_r;
    logic [31:0]        rdata_r;
    logic               err_r;
    logic [31:0]        mem_r [DEPTH_WORDS];

    assign gnt      = req && (state_r == ST_IDLE);
    assign accept_s = gnt;

    // Addresses below BASE_ADDR wrap to a large offset and decode as out of range.
    assign offset_s      = addr - BASE_ADDR;
    assign in_range_in_s = (offset_s < WIN_BYTES);
    assign idx_in_s      = offset_s[IDX_W+1:2];

    // Next-state and wait counter logic
    always_comb begin
        state_nxt_s = state_r;
        cnt_nxt_s   = cnt_r;
        case (state_r)
            ST_IDLE: begin
                if (accept_s) begin
                    if (WAIT_STATES == 32'd0) begin
                        state_nxt_s = ST_RESP;
                    end else begin
                        state_nxt_s = ST_WAIT;
                        cnt_nxt_s   = WAIT_LOAD;
                    end
                end else begin
                    state_nxt_s = ST_IDLE;
                end
            end
            ST_WAIT: begin
                if (cnt_r == 4'd0) begin
                    state_nxt_s = ST_RESP;
                end else begin
                    cnt_nxt_s = cnt_r - 4'd1;
                end
            end
            ST_RESP: begin
                state_nxt_s = ST_IDLE;
            end
            default: begin
                state_nxt_s = ST_IDLE;
                cnt_nxt_s   = 4'd0;
            end
        endcase
    end

    // With zero wait states the commit happens in the accept cycle, so use live bus inputs in IDLE.
    always_comb begin
        if (state_r == ST_IDLE) begin
            cur_in_range_s = in_range_in_s;
            cur_idx_s      = idx_in_s;
            cur_we_s       = we;
            cur_be_s       = be;
            cur_wdata_s    = wdata;
        end else begin
            cur_in_range_s = in_range_r;
            cur_idx_s      = idx_r;
            cur_we_s       = we_r;
            cur_be_s       = be_r;
            cur_wdata_s    = wdata_r;
        end
    end

    assign commit_s = (state_nxt_s == ST_RESP) && (state_r != ST_RESP) && !rst;

    // State register and wait counter
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r <= ST_IDLE;
            cnt_r   <= 4'd0;
        end else begin
            state_r <= state_nxt_s;
            cnt_r   <= cnt_nxt_s;
        end
    end

    // Capture the accepted request
    always_ff @(posedge clk) begin
        if (rst) begin
            in_range_r <= 1'b0;
            idx_r      <= '0;
            we_r       <= 1'b0;
            be_r       <= 4'd0;
            wdata_r    <= 32'd0;
        end else if (accept_s) begin
            in_range_r <= in_range_in_s;
            idx_r      <= idx_in_s;
            we_r       <= we;
            be_r       <= be;
            wdata_r    <= wdata;
        end
    end

    // RAM byte-lane write on commit; contents are deliberately not reset
    always_ff @(posedge clk) begin
        if (commit_s && cur_in_range_s && cur_we_s) begin
            for (int i = 0; i < 4; i++) begin
                if (cur_be_s[i]) begin
                    mem_r[cur_idx_s][8*i +: 8] <= cur_wdata_s[8*i +: 8];
                end
            end
        end
    end

    // Response registers, zero everywhere except the RESP cycle
    always_ff @(posedge clk) begin
        if (rst) begin
            rvalid_r <= 1'b0;
            rdata_r  <= 32'd0;
            err_r    <= 1'b0;
        end else if (commit_s) begin
            rvalid_r <= 1'b1;
            err_r    <= !cur_in_range_s;
            if (cur_in_range_s && !cur_we_s) begin
                rdata_r <= mem_r[cur_idx_s];
            end else begin
                rdata_r <= 32'd0;
            end
        end else begin
            rvalid_r <= 1'b0;
            rdata_r  <= 32'd0;
            err_r    <= 1'b0;
        end
    end

    assign rvalid = rvalid_r;
    assign rdata  = rdata_r;
    assign err    = err_r;

endmodule

// File: tb/tb_dbus_ram_responder.sv
// Directed bench for dbus_ram_responder with three instances: WAIT_STATES = 1, 0 and 3.
// Stimulus is driven and outputs are sampled around the falling clock edge.
module tb_dbus_ram_responder;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        req    [3];
    logic        we     [3];
    logic [3:0]  be     [3];
    logic [31:0] addr   [3];
    logic [31:0] wdata  [3];
    logic        gnt    [3];
    logic        rvalid [3];
    logic [31:0] rdata  [3];
    logic        err    [3];

    int checks = 0;
    int errors = 0;
    int cyc    = 0;

    always #5 clk = ~clk;

    // Cycle index, used to measure grant-to-response latency
    always @(posedge clk) cyc <= cyc + 1;

    dbus_ram_responder #(.DEPTH_WORDS(1024), .WAIT_STATES(1), .BASE_ADDR(32'h0001_0000)) u_ws1 (
        .clk(clk), .rst(rst), .req(req[0]), .we(we[0]), .be(be[0]), .addr(addr[0]),
        .wdata(wdata[0]), .gnt(gnt[0]), .rvalid(rvalid[0]), .rdata(rdata[0]), .err(err[0]));

    dbus_ram_responder #(.DEPTH_WORDS(1024), .WAIT_STATES(0), .BASE_ADDR(32'h0001_0000)) u_ws0 (
        .clk(clk), .rst(rst), .req(req[1]), .we(we[1]), .be(be[1]), .addr(addr[1]),
        .wdata(wdata[1]), .gnt(gnt[1]), .rvalid(rvalid[1]), .rdata(rdata[1]), .err(err[1]));

    dbus_ram_responder #(.DEPTH_WORDS(1024), .WAIT_STATES(3), .BASE_ADDR(32'h0001_0000)) u_ws3 (
        .clk(clk), .rst(rst), .req(req[2]), .we(we[2]), .be(be[2]), .addr(addr[2]),
        .wdata(wdata[2]), .gnt(gnt[2]), .rvalid(rvalid[2]), .rdata(rdata[2]), .err(err[2]));

    // Compare an observed value against its expectation and record the result
    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // One complete transaction on instance k; tg/tv are the grant and rvalid cycles (-1 on timeout)
    task automatic txn(input int k, input logic w, input logic [3:0] b, input logic [31:0] a,
                       input logic [31:0] d, output logic [31:0] rd, output logic e,
                       output int tg, output int tv);
        rd = 32'hxxxx_xxxx;
        e  = 1'bx;
        tg = -1;
        tv = -1;
        @(negedge clk);
        req[k] = 1'b1; we[k] = w; be[k] = b; addr[k] = a; wdata[k] = d;
        for (int n = 0; n < 50; n++) begin
            #1;
            if (gnt[k]) begin
                tg = cyc;
                break;
            end
            @(negedge clk);
        end
        if (tg < 0) begin
            errors++;
            $error("FAIL timeout waiting for gnt on instance %0d", k);
        end
        @(negedge clk);
        req[k] = 1'b0;
        for (int n = 0; n < 50; n++) begin
            #1;
            if (rvalid[k]) begin
                tv = cyc;
                rd = rdata[k];
                e  = err[k];
                break;
            end
            @(negedge clk);
        end
        if (tv < 0) begin
            errors++;
            $error("FAIL timeout waiting for rvalid on instance %0d", k);
        end
    endtask

    initial begin
        logic [31:0] rd;
        logic        e;
        int          tg;
        int          tv;
        int          t0;

        for (int k = 0; k < 3; k++) begin
            req[k] = 1'b0; we[k] = 1'b0; be[k] = 4'h0; addr[k] = 32'h0; wdata[k] = 32'h0;
        end

        // Reset state
        repeat (3) @(negedge clk);
        #1;
        chk("rst_rvalid", rvalid[0], 1'b0);
        chk("rst_rdata", rdata[0], 32'h0);
        chk("rst_err", err[2], 1'b0);
        req[0] = 1'b1;
        #1;
        chk("rst_gnt_idle", gnt[0], 1'b1);
        req[0] = 1'b0;
        rst = 1'b0;

        // WAIT_STATES=1: full-word write then read
        txn(0, 1'b1, 4'hF, 32'h0001_0004, 32'hDEAD_BEEF, rd, e, tg, tv);
        chk("ws1_wr_lat", tv - tg, 2);
        chk("ws1_wr_err", e, 1'b0);
        chk("ws1_wr_rdata", rd, 32'h0);
        txn(0, 1'b0, 4'h0, 32'h0001_0004, 32'h0, rd, e, tg, tv);
        chk("ws1_rd_lat", tv - tg, 2);
        chk("ws1_rd_data", rd, 32'hDEAD_BEEF);
        chk("ws1_rd_err", e, 1'b0);

        // Partial byte-enable write
        txn(0, 1'b1, 4'b0101, 32'h0001_0004, 32'h1122_3344, rd, e, tg, tv);
        txn(0, 1'b0, 4'h0, 32'h0001_0004, 32'h0, rd, e, tg, tv);
        chk("be_merge", rd, 32'hDE22_BE44);

        // be=0 write leaves the word alone
        txn(0, 1'b1, 4'b0000, 32'h0001_0004, 32'hFFFF_FFFF, rd, e, tg, tv);
        txn(0, 1'b0, 4'h0, 32'h0001_0004, 32'h0, rd, e, tg, tv);
        chk("be_zero_noop", rd, 32'hDE22_BE44);

        // Out-of-range accesses
        txn(0, 1'b0, 4'h0, 32'h0001_1000, 32'h0, rd, e, tg, tv);
        chk("oor_rd_err", e, 1'b1);
        chk("oor_rd_data", rd, 32'h0);
        txn(0, 1'b1, 4'hF, 32'h0001_0000, 32'hCAFE_F00D, rd, e, tg, tv);
        txn(0, 1'b1, 4'hF, 32'h0000_0000, 32'h1234_5678, rd, e, tg, tv);
        chk("oor_wr_err", e, 1'b1);
        txn(0, 1'b0, 4'h0, 32'h0001_0000, 32'h0, rd, e, tg, tv);
        chk("oor_wr_nochange", rd, 32'hCAFE_F00D);
        txn(0, 1'b0, 4'h0, 32'h0000_FFFC, 32'h0, rd, e, tg, tv);
        chk("below_base_err", e, 1'b1);

        // Last word of the window is still in range
        txn(0, 1'b1, 4'hF, 32'h0001_0FFC, 32'h0A0B_0C0D, rd, e, tg, tv);
        chk("last_wr_err", e, 1'b0);
        txn(0, 1'b0, 4'h0, 32'h0001_0FFC, 32'h0, rd, e, tg, tv);
        chk("last_rd_data", rd, 32'h0A0B_0C0D);

        // WAIT_STATES=0: single write, then three reads with req held high
        txn(1, 1'b1, 4'hF, 32'h0001_0008, 32'h55AA_55AA, rd, e, tg, tv);
        chk("ws0_wr_lat", tv - tg, 1);
        @(negedge clk);
        req[1] = 1'b1; we[1] = 1'b0; be[1] = 4'h0; addr[1] = 32'h0001_0008;
        for (int i = 0; i < 6; i++) begin
            #1;
            chk("ws0_stream_gnt", gnt[1], ((i % 2) == 0));
            chk("ws0_stream_rvalid", rvalid[1], ((i % 2) == 1));
            if ((i % 2) == 1) begin
                chk("ws0_stream_rdata", rdata[1], 32'h55AA_55AA);
            end else begin
                chk("ws0_stream_rdata_idle", rdata[1], 32'h0);
            end
            @(negedge clk);
        end
        req[1] = 1'b0;

        // WAIT_STATES=3: reset during WAIT aborts the write
        txn(2, 1'b1, 4'hF, 32'h0001_000C, 32'h0102_0304, rd, e, tg, tv);
        chk("ws3_wr_lat", tv - tg, 4);
        @(negedge clk);
        req[2] = 1'b1; we[2] = 1'b1; be[2] = 4'hF; addr[2] = 32'h0001_000C; wdata[2] = 32'hFFFF_FFFF;
        #1;
        chk("ws3_abort_gnt", gnt[2], 1'b1);
        t0 = cyc;
        @(negedge clk);
        req[2] = 1'b0;
        #1;
        chk("ws3_abort_rv_t1", rvalid[2], 1'b0);
        @(negedge clk);
        rst = 1'b1;
        #1;
        chk("ws3_abort_cyc", cyc - t0, 2);
        chk("ws3_abort_rv_t2", rvalid[2], 1'b0);
        @(negedge clk);
        rst = 1'b0;
        #1;
        chk("ws3_post_rst_rvalid", rvalid[2], 1'b0);
        chk("ws3_post_rst_rdata", rdata[2], 32'h0);
        chk("ws3_post_rst_err", err[2], 1'b0);
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            #1;
            chk("ws3_no_late_rvalid", rvalid[2], 1'b0);
        end
        txn(2, 1'b0, 4'h0, 32'h0001_000C, 32'h0, rd, e, tg, tv);
        chk("ws3_not_committed", rd, 32'h0102_0304);
        chk("ws3_rd_lat", tv - tg, 4);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/dbus_ram_responder.md
Name: dbus_ram_responder

Overview:
- Single-port data RAM that acts as the responder on the core's data bus, serving the load/store requests the LSU issues.
- Accepts one request at a time with a req/gnt handshake and inserts a programmable number of wait states.
- Returns a single-cycle rvalid response carrying read data or an error flag.
- Sits in the SoC next to the core, decoding its own address window.

Parameters:
DEPTH_WORDS, 1024, number of 32-bit words; power of two, >= 2
WAIT_STATES, 1, extra cycles between grant and response; 0..15
BASE_ADDR, 32'h0001_0000, byte address of word 0; aligned to DEPTH_WORDS*4

Ports:
clk  input  1  clock, all logic on rising edge
rst  input  1  synchronous reset, active-high
req  input  1  request valid from initiator
we  input  1  1 = write, 0 = read; sampled with req
be  input  4  byte enables for writes; be[i] selects wdata[8i+7:8i]
addr  input  32  byte address; addr[1:0] ignored (word access)
wdata  input  32  write data
gnt  output  1  request accepted this cycle
rvalid  output  1  response valid, one-cycle pulse
rdata  output  32  read data, valid while rvalid
err  output  1  response is error (address out of window), valid while rvalid

Behaviour:
- Clock and reset: one clock, clk. Reset is synchronous and active-high on rst.
- Reset: state=IDLE, rvalid=0, rdata=0, err=0, wait counter=0. RAM contents are not reset.
- gnt is combinational: gnt = req && state==IDLE. gnt is never asserted outside IDLE.
- Handshake: a request is accepted on a cycle where req && gnt. The initiator holds req/we/be/addr/wdata until gnt. On accept, addr, we, be and wdata are latched internally.
- FSM states:
  - IDLE: on accept, go to WAIT if WAIT_STATES>0 (counter loaded with WAIT_STATES-1), else go to RESP.
  - WAIT: counter decrements each cycle. When the counter reaches 0, go to RESP next cycle.
  - RESP: rvalid=1 for exactly this one cycle, then return to IDLE. No new grant is given in RESP; the next accept happens at the earliest in the cycle after RESP.
- Latency: if accepted in cycle T, rvalid is high in cycle T+1+WAIT_STATES. Back-to-back throughput is one transaction per 2+WAIT_STATES cycles.
- Address decode: offset = addr - BASE_ADDR (32-bit unsigned). The address is in range iff offset < DEPTH_WORDS*4. Word index = offset[log2(DEPTH_WORDS)+1:2].
- Commit happens on the transition into RESP:
  - In-range write: mem[idx] byte lanes with be set are updated; other lanes are unchanged. rdata is registered as 0.
  - In-range read: rdata is registered as mem[idx] (full word; byte/half extraction and sign extension are the LSU's job). A write with be=0 behaves as a no-op write.
  - Out of range: no RAM write; rdata=0, err=1.
- err and rdata are valid only while rvalid=1. They are held at 0 outside RESP.
- Read-after-write: a read accepted after a write's RESP cycle returns the new data.
- Reset mid-operation: rst in WAIT or RESP returns to IDLE at once, with no further rvalid. A write whose RESP transition has not occurred is not committed.
- req deasserted while not granted is legal. req held high during WAIT/RESP is not accepted until IDLE.

Test Plan:
- WAIT_STATES=1. Write addr=0x0001_0004, wdata=0xDEADBEEF, be=4'hF, accepted at T. Then read the same address. -> Write rvalid at T+2 with err=0, rdata=0. Read rvalid 2 cycles after its grant with rdata=0xDEADBEEF.
- Byte enables: mem[1]=0xDEADBEEF, write wdata=0x11223344, be=4'b0101, then read. -> rdata=0xDE22BE44.
- Out of range: read addr=0x0001_1000 with DEPTH_WORDS=1024. Then write addr=0x0000_0000 and read back word 0. -> rvalid with err=1, rdata=0. The write is flagged err=1 and RAM is unchanged.
- req held high continuously for 3 reads, WAIT_STATES=0. -> gnt at cycles T, T+2, T+4; rvalid at T+1, T+3, T+5; gnt=0 on every rvalid cycle.
- WAIT_STATES=3. Write accepted at T, rst pulsed at T+2, then read the same address. -> No rvalid before T+4. The old contents are returned, proving the write was not committed. After rst, rvalid=0, rdata=0, err=0.
